// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, add/sub ALU, OUT and the shared W bus.
// Driven each T-state by the controller's 12-bit control word; returns the opcode nibble.
module sap1_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              Cp,
    input  logic              Ep,
    input  logic              Lm_barra,
    input  logic              CE_barra,
    input  logic              Li_barra,
    input  logic              Ei_barra,
    input  logic              La_barra,
    input  logic              Ea,
    input  logic              Su,
    input  logic              Eu,
    input  logic              Lb_barra,
    input  logic              Lo_barra,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        ri,
    output logic [DATA_W-1:0] out_reg,
    output logic [DATA_W-1:0] bus,
    output logic              bus_conflict,
    output logic              halted
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] out_r;
    logic              conflict_r;
    logic [DATA_W-1:0] ram_r [DEPTH];

    logic [DATA_W-1:0] ram_rd_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] bus_s;
    logic [2:0]        n_drv_s;

    // Number of units currently enabled onto the W bus.
    function automatic logic [2:0] count_drivers(input logic [4:0] en);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'b00, en[i]};
        end
        return n;
    endfunction

    assign ram_rd_s = ram_r[mar_r];
    // Subtraction is A + ~B + 1; the carry out is simply dropped.
    assign alu_s    = a_r + (b_r ^ {DATA_W{Su}}) + {{(DATA_W-1){1'b0}}, Su};
    assign n_drv_s  = count_drivers({Ep, ~CE_barra, ~Ei_barra, Ea, Eu});

    // Priority bus mux; a well-formed control word enables at most one driver.
    always_comb begin
        bus_s = {DATA_W{1'b0}};
        if (Ep) begin
            bus_s = {{(DATA_W-ADDR_W){1'b0}}, pc_r};
        end else if (!CE_barra) begin
            bus_s = ram_rd_s;
        end else if (!Ei_barra) begin
            bus_s = {{(DATA_W-4){1'b0}}, ir_r[3:0]};
        end else if (Ea) begin
            bus_s = a_r;
        end else if (Eu) begin
            bus_s = alu_s;
        end else begin
            bus_s = {DATA_W{1'b0}};
        end
    end

    // Loader write port; memory contents survive clr.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            ram_r[prog_addr] <= prog_data;
        end
    end

    // Architectural registers: every load samples this cycle's bus value.
    always_ff @(posedge clock) begin
        if (clr) begin
            pc_r       <= {ADDR_W{1'b0}};
            mar_r      <= {ADDR_W{1'b0}};
            ir_r       <= {DATA_W{1'b0}};
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            out_r      <= {DATA_W{1'b0}};
            conflict_r <= 1'b0;
        end else begin
            if (Cp)        pc_r  <= pc_r + PC_STEP;
            if (!Lm_barra) mar_r <= bus_s[ADDR_W-1:0];
            if (!Li_barra) ir_r  <= bus_s;
            if (!La_barra) a_r   <= bus_s;
            if (!Lb_barra) b_r   <= bus_s;
            if (!Lo_barra) out_r <= bus_s;
            conflict_r <= (n_drv_s > 3'd1);
        end
    end

    assign ri           = ir_r[DATA_W-1:DATA_W-4];
    assign halted       = (ri == 4'hF);
    assign out_reg      = out_r;
    assign bus          = bus_s;
    assign bus_conflict = conflict_r;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: runs a small SAP-1 program plus corner cases,
// with every expected value worked out by hand.
module tb_sap1_datapath;

    localparam logic [11:0] IDLE    = 12'h3E3;
    localparam logic [11:0] T1_FET  = 12'h5E3;  // Ep, Lm
    localparam logic [11:0] T2_INC  = 12'hBE3;  // Cp
    localparam logic [11:0] T3_IR   = 12'h263;  // CE, Li
    localparam logic [11:0] T4_MAR  = 12'h1A3;  // Ei, Lm
    localparam logic [11:0] RAM_A   = 12'h2C3;  // CE, La
    localparam logic [11:0] RAM_B   = 12'h2E1;  // CE, Lb
    localparam logic [11:0] ADD_A   = 12'h3C7;  // Eu, La
    localparam logic [11:0] SUB_A   = 12'h3CF;  // Su, Eu, La
    localparam logic [11:0] A_OUT   = 12'h3F2;  // Ea, Lo
    localparam logic [11:0] SHOW_A  = 12'h3F3;  // Ea
    localparam logic [11:0] SHOW_PC = 12'h7E3;  // Ep
    localparam logic [11:0] SHOW_IR = 12'h3A3;  // Ei
    localparam logic [11:0] SHOW_M  = 12'h2E3;  // CE
    localparam logic [11:0] SHOW_U  = 12'h3E7;  // Eu
    localparam logic [11:0] INC_SHW = 12'hFE3;  // Cp, Ep
    localparam logic [11:0] EP_EA   = 12'h7F3;  // Ep, Ea (conflict)

    logic       clock, clr;
    logic       Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra;
    logic       La_barra, Ea, Su, Eu, Lb_barra, Lo_barra;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] ri;
    logic [7:0] out_reg, bus;
    logic       bus_conflict, halted;

    int n_vec = 0;
    int n_bad = 0;

    sap1_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clock(clock), .clr(clr),
        .Cp(Cp), .Ep(Ep), .Lm_barra(Lm_barra), .CE_barra(CE_barra),
        .Li_barra(Li_barra), .Ei_barra(Ei_barra), .La_barra(La_barra), .Ea(Ea),
        .Su(Su), .Eu(Eu), .Lb_barra(Lb_barra), .Lo_barra(Lo_barra),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ri(ri), .out_reg(out_reg), .bus(bus),
        .bus_conflict(bus_conflict), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge and are settled well before the next rise.
    task automatic drive(input logic [11:0] cw);
        {Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra,
         La_barra, Ea, Su, Eu, Lb_barra, Lo_barra} = cw;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cycle(input logic [11:0] cw);
        drive(cw);
        tick();
    endtask

    task automatic load_ram(input logic [3:0] addr, input logic [7:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        cycle(IDLE);
        prog_we = 1'b0;
    endtask

    task automatic fetch();
        cycle(T1_FET);
        cycle(T2_INC);
        cycle(T3_IR);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        cycle(IDLE);
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
        drive(IDLE);
        @(negedge clock);
        // Program loaded while clr is held: writes must still land.
        load_ram(4'h0, 8'h09); load_ram(4'h1, 8'h1A); load_ram(4'h2, 8'h2B);
        load_ram(4'h3, 8'hE0); load_ram(4'h4, 8'hF0);
        load_ram(4'h9, 8'h10); load_ram(4'hA, 8'h14); load_ram(4'hB, 8'h18);
        clr = 1'b0;
        drive(IDLE);
        check("rst_ri", ri, 4'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_out", out_reg, 8'h00);
        check("rst_conflict", bus_conflict, 1'b0);
        check("idle_bus", bus, 8'h00);

        // LDA 9
        fetch();
        check("lda_ri", ri, 4'h0);
        cycle(T4_MAR);
        drive(RAM_A); check("lda_bus", bus, 8'h10); tick();
        cycle(IDLE);
        drive(SHOW_A); check("lda_a", bus, 8'h10); tick();
        // ADD A
        fetch();
        check("add_ri", ri, 4'h1);
        cycle(T4_MAR); cycle(RAM_B);
        drive(ADD_A); check("add_alu", bus, 8'h24); tick();
        drive(SHOW_A); check("add_a", bus, 8'h24); tick();
        // SUB B
        fetch();
        check("sub_ri", ri, 4'h2);
        cycle(T4_MAR); cycle(RAM_B);
        drive(SUB_A); check("sub_alu", bus, 8'h0C); tick();
        // OUT
        fetch();
        check("out_ri", ri, 4'hE);
        check("out_pre", out_reg, 8'h00);
        cycle(A_OUT); cycle(IDLE); cycle(IDLE);
        check("out_reg", out_reg, 8'h0C);
        // HLT
        fetch();
        check("hlt_ri", ri, 4'hF);
        check("hlt_halted", halted, 1'b1);
        drive(SHOW_PC); check("hlt_pc", bus, 8'h05); tick();

        // Reset mid-instruction: MAR is 4 after the HLT fetch.
        load_ram(4'h4, 8'h22); cycle(RAM_A);
        load_ram(4'h4, 8'h1A); cycle(T3_IR);
        check("pre_rst_ri", ri, 4'h1);
        drive(SHOW_A); check("pre_rst_a", bus, 8'h22); tick();
        clr = 1'b1;
        cycle(RAM_A);
        clr = 1'b0;
        drive(IDLE);
        check("mid_rst_ri", ri, 4'h0);
        check("mid_rst_halted", halted, 1'b0);
        check("mid_rst_out", out_reg, 8'h00);
        drive(SHOW_A);  check("mid_rst_a", bus, 8'h00);
        drive(SHOW_PC); check("mid_rst_pc", bus, 8'h00);
        drive(SHOW_IR); check("mid_rst_ir", bus, 8'h00);
        drive(SHOW_U);  check("mid_rst_b", bus, 8'h00);
        drive(SHOW_M);  check("mid_rst_mar", bus, 8'h09);
        tick();

        // RAM collision at MAR = 9
        for (int i = 0; i < 9; i++) cycle(T2_INC);
        cycle(T1_FET);
        prog_we = 1'b1; prog_addr = 4'h9; prog_data = 8'h77;
        drive(SHOW_M); check("coll_old", bus, 8'h10); tick();
        prog_we = 1'b0;
        drive(SHOW_M); check("coll_new", bus, 8'h77); tick();
        // RAM[A] survived the reset
        cycle(T2_INC); cycle(T1_FET);
        drive(SHOW_M); check("ram_a_kept", bus, 8'h14); tick();

        // Subtract underflow: 5 - 7
        do_reset();
        load_ram(4'h0, 8'h05); cycle(RAM_A);
        load_ram(4'h0, 8'h07); cycle(RAM_B);
        drive(SUB_A); check("under_alu", bus, 8'hFE); tick();
        drive(SHOW_A); check("under_a", bus, 8'hFE); tick();

        // PC wrap
        do_reset();
        for (int i = 0; i < 15; i++) cycle(T2_INC);
        drive(INC_SHW); check("wrap_last", bus, 8'h0F); tick();
        drive(SHOW_PC); check("wrap_pc", bus, 8'h00); tick();

        // Bus conflict: PC = 3, A = 0x55
        load_ram(4'h0, 8'h55); cycle(RAM_A);
        for (int i = 0; i < 3; i++) cycle(T2_INC);
        check("conf_pre", bus_conflict, 1'b0);
        drive(EP_EA); check("conf_bus", bus, 8'h03); tick();
        check("conf_set", bus_conflict, 1'b1);
        drive(SHOW_A); check("conf_a", bus, 8'h55); tick();
        check("conf_clear", bus_conflict, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
